instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Parametrised successor to the CPU core's instruction/cycle controller. Holds the instruction register and the T-cycle counter, and adds several capabilities:
- RDY stall
- NMI edge detection and IRQ level sampling
- Reset/NMI/IRQ injection of the BRK opcode at instruction fetch
- Sticky cycle-overflow detection
Sits between the pre-decode register and the decode ROM/timing logic of the 6502 core.

Parameters:
CYCLE_W, 3, width of T-cycle counter.
IR_W, 8, opcode width.
BRK_OPCODE, 8'h00, opcode forced into ir on interrupt injection.

Ports:
clk_ph1  in  1  phase-1 clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-low.
rdy  in  1  1=advance, 0=stall (hold sequencing state).
i_cycle  in  1  increment cycle counter.
r_cycle  in  1  reset cycle counter to 0 (priority over i_cycle).
pd  in  IR_W  pre-decode opcode.
nmi_n  in  1  NMI request, falling-edge sensitive.
irq_n  in  1  IRQ request, level, active-low.
i_flag  in  1  processor I flag; 1 masks IRQ.
ir  out  IR_W  instruction register.
cycle  out  CYCLE_W  current T-cycle.
sync  out  1  1 while cycle==1 (opcode cycle).
int_src  out  2  source of current ir: 0 none, 1 IRQ, 2 NMI, 3 RESET.
cycle_ovf  out  1  sticky: counter wrapped via i_cycle.
halted  out  1  JAM halt (see Optional Feature); 0 if not compiled.

Behaviour:
Reset (rst==0 at clk edge):
- cycle = all ones; ir = 0; int_src = 0; cycle_ovf = 0; halted = 0.
- nmi_pending = 0; nmi_prev = 1; reset_pending = 1.

Next-cycle and stall:
- next_cycle = r_cycle ? 0 : i_cycle ? cycle+1 (mod 2^CYCLE_W) : cycle.
- When rdy==0 or halted==1: cycle, ir, int_src and reset_pending hold; i_cycle and r_cycle are ignored.
- NMI edge detection runs regardless of rdy and halted.

Fetch (rdy==1 and next_cycle==1):
- Priority: reset_pending > nmi_pending > (irq_n==0 && i_flag==0).
- If any is active: ir = BRK_OPCODE; int_src = 3/2/1 respectively; the consumed pending flag clears.
- Otherwise: ir = pd; int_src = 0.
- Non-fetch cycles: ir and int_src hold.

First instruction after reset:
- From cycle=all ones, one i_cycle pulse gives 0; the next gives 1, which fetches.
- That first fetch always loads BRK_OPCODE with int_src=3.

NMI edge detection:
- Each edge: nmi_prev = nmi_n.
- Falling edge (nmi_prev==1 && nmi_n==0) sets nmi_pending.
- If a new edge and a consume occur in the same cycle, pending stays 1.
- A held-low nmi_n produces only one NMI.

IRQ:
- Sampled only at fetch; not latched.

cycle_ovf:
- Set when rdy==1, r_cycle==0, i_cycle==1 and cycle==all ones, except during the first wrap after reset (reset_pending==1).
- Cleared only by reset.

sync:
- Combinational from registered cycle (cycle==1).

Reset mid-instruction:
- Overrides everything; sequence restarts as above.

Optional Feature:
Macro: INSTR_SEQ_JAM_HALT_EN
- Defined: when the ir loaded at fetch (non-injected) is a JAM opcode (x2 with high nibble in {0-7,9,B,D,F}), halted is set on that edge. While halted, cycle and ir freeze and only rst clears the halt. NMI is latched but not serviced.
- Undefined: JAM opcodes load normally; halted is tied to 0.

Decomposition:
Shared package nes_cpu_pkg:
- int_src encodings INT_NONE, INT_IRQ, INT_NMI, INT_RESET.
- BRK_OPCODE default.
- is_jam(opcode) function.

Sub-module: nmi_edge_detect (nmi_prev, nmi_pending, set/consume priority). The rest stays flat.

Test Plan:
1. rst=0 one clk, then rst=1, i_cycle=1, pd=8'hA9 -> cycle 7, 0, 1; at cycle 1 ir=8'h00, int_src=3; cycle_ovf=0.
2. Following fetch with pd=8'hA9 and no interrupts -> ir=8'hA9, int_src=0, sync=1 only while cycle==1.
3. rdy=0 for 3 clks with i_cycle=1 mid-instruction (cycle=2) -> cycle stays 2, ir unchanged; rdy=1 -> cycle 3.
4. nmi_n 1->0 held low, plus irq_n=0 and i_flag=0 at the next fetch -> ir=8'h00, int_src=2; at the following fetch int_src=1 (IRQ), NMI not repeated.
5. irq_n=0 with i_flag=1 at fetch, pd=8'hEA -> ir=8'hEA, int_src=0; i_cycle held from cycle=7 after the first instruction -> cycle_ovf=1, stays 1 until rst.
6. With INSTR_SEQ_JAM_HALT_EN: fetch pd=8'h02 -> halted=1, cycle frozen despite i_cycle=1; rst=0 -> halted=0.

Source files
------------

// File: rtl/nes_cpu_pkg.sv
// ---------------------------------------------------------------------------
// nes_cpu_pkg
// Shared definitions for the 6502 core's instruction sequencing logic:
//   - int_src_t : encoding of the source of the current instruction register
//                 (none, IRQ, NMI, RESET)
//   - BRK_OPCODE_DEFAULT : opcode injected on interrupt/reset entry
//   - is_jam()  : recognises the undocumented JAM/KIL opcodes that lock the CPU
// ---------------------------------------------------------------------------
package nes_cpu_pkg;

    typedef enum logic [1:0] {
        INT_NONE  = 2'd0,
        INT_IRQ   = 2'd1,
        INT_NMI   = 2'd2,
        INT_RESET = 2'd3
    } int_src_t;

    localparam logic [7:0] BRK_OPCODE_DEFAULT = 8'h00;

    // JAM opcodes are x2 where the high nibble is 0-7 or odd (9, B, D, F).
    function automatic logic is_jam(input logic [7:0] opcode);
        return (opcode[3:0] == 4'h2) && (!opcode[7] || opcode[4]);
    endfunction

endpackage

// File: rtl/instr_sequencer_nmi_edge_detect.sv
// ---------------------------------------------------------------------------
// nmi_edge_detect
// Latches a falling edge on nmi_n into a pending flag that stays set until the
// sequencer consumes it at an instruction fetch. Runs every clock, independent
// of RDY and JAM halt, so an NMI arriving during a stall is not lost.
// Ports:
//   clk_ph1  in   phase-1 clock
//   rst      in   synchronous reset, active-low
//   nmi_n    in   NMI request line, falling-edge sensitive
//   consume  in   fetch is servicing the pending NMI this cycle
//   pending  out  an NMI edge has been seen and not yet serviced
// ---------------------------------------------------------------------------
module nmi_edge_detect (
    input  logic clk_ph1,
    input  logic rst,
    input  logic nmi_n,
    input  logic consume,
    output logic pending
);

    logic nmi_prev;
    logic fall;

    assign fall = nmi_prev && !nmi_n;

    // A fresh edge wins over a consume in the same cycle, so back-to-back
    // NMIs are never dropped.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            nmi_prev <= 1'b1;
            pending  <= 1'b0;
        end else begin
            nmi_prev <= nmi_n;
            if (fall) begin
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Instruction register and T-cycle counter for the 6502 core. Sits between the
// pre-decode register and the decode ROM / timing logic. Handles RDY stalls,
// injects BRK_OPCODE at fetch for pending RESET/NMI/unmasked IRQ, and flags a
// sticky cycle-counter overflow.
// Optional feature macro: INSTR_SEQ_JAM_HALT_EN -- when defined, fetching a
// JAM opcode halts sequencing until reset; otherwise halted is tied to 0.
// Ports:
//   clk_ph1    in   phase-1 clock, rising edge
//   rst        in   synchronous reset, active-low
//   rdy        in   1 advance, 0 stall
//   i_cycle    in   increment cycle counter
//   r_cycle    in   clear cycle counter (priority over i_cycle)
//   pd         in   pre-decode opcode
//   nmi_n      in   NMI request, falling-edge sensitive
//   irq_n      in   IRQ request, level, active-low
//   i_flag     in   processor I flag, 1 masks IRQ
//   ir         out  instruction register
//   cycle      out  current T-cycle
//   sync       out  opcode cycle indicator (cycle == 1)
//   int_src    out  source of current ir (none/IRQ/NMI/RESET)
//   cycle_ovf  out  sticky counter wrap via i_cycle
//   halted     out  JAM halt
// ---------------------------------------------------------------------------
module instr_sequencer
    import nes_cpu_pkg::*;
#(
    parameter int              CYCLE_W    = 3,
    parameter int              IR_W       = 8,
    parameter logic [IR_W-1:0] BRK_OPCODE = IR_W'(BRK_OPCODE_DEFAULT)
) (
    input  logic               clk_ph1,
    input  logic               rst,
    input  logic               rdy,
    input  logic               i_cycle,
    input  logic               r_cycle,
    input  logic [IR_W-1:0]    pd,
    input  logic               nmi_n,
    input  logic               irq_n,
    input  logic               i_flag,
    output logic [IR_W-1:0]    ir,
    output logic [CYCLE_W-1:0] cycle,
    output logic               sync,
    output logic [1:0]         int_src,
    output logic               cycle_ovf,
    output logic               halted
);

    localparam logic [CYCLE_W-1:0] CYCLE_ONES = '1;
    localparam logic [CYCLE_W-1:0] CYCLE_ONE  = CYCLE_W'(1);

    logic [CYCLE_W-1:0] cycle_q;
    logic [CYCLE_W-1:0] next_cycle;
    logic [IR_W-1:0]    ir_q;
    logic [IR_W-1:0]    ir_next;
    int_src_t           src_q;
    int_src_t           src_next;
    logic               reset_pending;
    logic               ovf_q;
    logic               halted_q;
    logic               nmi_pending;
    logic               nmi_consume;
    logic               advance;
    logic               fetch;
    logic               irq_take;
    logic               inject;
    logic               ovf_set;
    logic               halt_set;

    nmi_edge_detect u_nmi (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .nmi_n   (nmi_n),
        .consume (nmi_consume),
        .pending (nmi_pending)
    );

    // Sequencing decisions for this cycle. RESET outranks NMI outranks IRQ;
    // only a fetch (next cycle == 1 while advancing) can load ir.
    always_comb begin
        next_cycle = cycle_q;
        ir_next    = pd;
        src_next   = INT_NONE;

        if (r_cycle) begin
            next_cycle = '0;
        end else if (i_cycle) begin
            next_cycle = cycle_q + CYCLE_ONE;
        end

        advance  = rdy && !halted_q;
        fetch    = advance && (next_cycle == CYCLE_ONE);
        irq_take = !irq_n && !i_flag;
        inject   = reset_pending || nmi_pending || irq_take;

        if (reset_pending) begin
            ir_next  = BRK_OPCODE;
            src_next = INT_RESET;
        end else if (nmi_pending) begin
            ir_next  = BRK_OPCODE;
            src_next = INT_NMI;
        end else if (irq_take) begin
            ir_next  = BRK_OPCODE;
            src_next = INT_IRQ;
        end

        nmi_consume = fetch && !reset_pending && nmi_pending;

        // The wrap from all-ones to 0 right after reset is expected and is not
        // an overflow.
        ovf_set = advance && !r_cycle && i_cycle &&
                  (cycle_q == CYCLE_ONES) && !reset_pending;

`ifdef INSTR_SEQ_JAM_HALT_EN
        halt_set = fetch && !inject && is_jam(8'(pd));
`else
        halt_set = 1'b0;
`endif
    end

    // Main sequencing state. Stalls (rdy low or halted) freeze everything here;
    // the NMI detector keeps running in its own module.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            cycle_q       <= CYCLE_ONES;
            ir_q          <= '0;
            src_q         <= INT_NONE;
            reset_pending <= 1'b1;
            ovf_q         <= 1'b0;
        end else begin
            if (advance) begin
                cycle_q <= next_cycle;
            end
            if (fetch) begin
                ir_q          <= ir_next;
                src_q         <= src_next;
                reset_pending <= 1'b0;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef INSTR_SEQ_JAM_HALT_EN
    // Once a JAM opcode is fetched only reset releases the core.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else if (halt_set) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halted_q = 1'b0;
`endif

    assign ir        = ir_q;
    assign cycle     = cycle_q;
    assign sync      = (cycle_q == CYCLE_ONE);
    assign int_src   = src_q;
    assign cycle_ovf = ovf_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Table-driven bench for instr_sequencer: each record is one clock of inputs
// plus the outputs expected after that edge. Expected records go into a
// scoreboard queue as stimulus is driven and are popped and compared one
// clock later. Hand-written sequences cover NMI during a stall and the JAM
// halt (which depends on INSTR_SEQ_JAM_HALT_EN).
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    typedef struct {
        bit         rst;
        bit         rdy;
        bit         ic;
        bit         rc;
        logic [7:0] pd;
        bit         nmi;
        bit         irq;
        bit         ifl;
        logic [2:0] cyc;
        logic [7:0] ir;
        logic [1:0] src;
        bit         ovf;
        bit         halt;
    } vec_t;

`ifdef INSTR_SEQ_JAM_HALT_EN
    localparam bit JAM_EN = 1'b1;
`else
    localparam bit JAM_EN = 1'b0;
`endif

    logic       clk_ph1;
    logic       rst;
    logic       rdy;
    logic       i_cycle;
    logic       r_cycle;
    logic [7:0] pd;
    logic       nmi_n;
    logic       irq_n;
    logic       i_flag;
    logic [7:0] ir;
    logic [2:0] cycle;
    logic       sync;
    logic [1:0] int_src;
    logic       cycle_ovf;
    logic       halted;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    vec_t sb[$];

    instr_sequencer dut (
        .clk_ph1   (clk_ph1),
        .rst       (rst),
        .rdy       (rdy),
        .i_cycle   (i_cycle),
        .r_cycle   (r_cycle),
        .pd        (pd),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .i_flag    (i_flag),
        .ir        (ir),
        .cycle     (cycle),
        .sync      (sync),
        .int_src   (int_src),
        .cycle_ovf (cycle_ovf),
        .halted    (halted)
    );

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t row(bit r, bit y, bit ic, bit rc, logic [7:0] p,
                                 bit n, bit q, bit f, logic [2:0] c,
                                 logic [7:0] i, logic [1:0] s, bit o, bit h);
        vec_t v;
        v.rst = r;  v.rdy = y;  v.ic = ic; v.rc = rc; v.pd = p;
        v.nmi = n;  v.irq = q;  v.ifl = f;
        v.cyc = c;  v.ir = i;   v.src = s; v.ovf = o; v.halt = h;
        return v;
    endfunction

    task automatic cmp(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue expected entry", idx);
            return;
        end
        e = sb.pop_front();
        cmp("cycle",     idx, 32'(cycle),     32'(e.cyc));
        cmp("ir",        idx, 32'(ir),        32'(e.ir));
        cmp("int_src",   idx, 32'(int_src),   32'(e.src));
        cmp("sync",      idx, 32'(sync),      32'(e.cyc == 3'd1));
        cmp("cycle_ovf", idx, 32'(cycle_ovf), 32'(e.ovf));
        cmp("halted",    idx, 32'(halted),    32'(e.halt));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        rst     = v.rst;
        rdy     = v.rdy;
        i_cycle = v.ic;
        r_cycle = v.rc;
        pd      = v.pd;
        nmi_n   = v.nmi;
        irq_n   = v.irq;
        i_flag  = v.ifl;
        sb.push_back(v);
        @(posedge clk_ph1);
        #1;
        checkOutput(idx);
    endtask

    initial begin
        // Columns: rst rdy ic rc pd nmi irq ifl | cycle ir src ovf halted
        // Reset, then the forced first BRK (first wrap must not flag overflow).
        vecs.push_back(row(0,1,0,0,8'hA9,1,1,0, 3'd7,8'h00,2'd0,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,1,1,0, 3'd0,8'h00,2'd0,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,1,1,0, 3'd1,8'h00,2'd3,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,1,1,0, 3'd2,8'h00,2'd3,0,0));
        vecs.push_back(row(1,1,0,1,8'hA9,1,1,0, 3'd0,8'h00,2'd3,0,0));
        // Normal fetch of A9, then RDY stall at cycle 2.
        vecs.push_back(row(1,1,1,0,8'hA9,1,1,0, 3'd1,8'hA9,2'd0,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,1,1,0, 3'd2,8'hA9,2'd0,0,0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(row(1,0,1,0,8'hA9,1,1,0, 3'd2,8'hA9,2'd0,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,1,1,0, 3'd3,8'hA9,2'd0,0,0));
        // NMI edge held low with IRQ asserted: NMI first, then IRQ, no repeat NMI.
        vecs.push_back(row(1,1,0,1,8'hA9,0,1,0, 3'd0,8'hA9,2'd0,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,0,0,0, 3'd1,8'h00,2'd2,0,0));
        vecs.push_back(row(1,1,0,1,8'hA9,0,0,0, 3'd0,8'h00,2'd2,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,0,0,0, 3'd1,8'h00,2'd1,0,0));
        // Masked IRQ fetches EA; free-running count wraps and sets sticky overflow.
        vecs.push_back(row(1,1,0,1,8'hEA,1,0,1, 3'd0,8'h00,2'd1,0,0));
        vecs.push_back(row(1,1,1,0,8'hEA,1,0,1, 3'd1,8'hEA,2'd0,0,0));
        for (int c = 2; c <= 7; c++)
            vecs.push_back(row(1,1,1,0,8'hEA,1,0,1, 3'(c),8'hEA,2'd0,0,0));
        vecs.push_back(row(1,1,1,0,8'hEA,1,0,1, 3'd0,8'hEA,2'd0,1,0));
        vecs.push_back(row(1,1,1,0,8'hEA,1,0,1, 3'd1,8'hEA,2'd0,1,0));
        // Reset mid-instruction clears overflow and restarts with RESET BRK.
        vecs.push_back(row(0,1,1,0,8'hEA,1,1,0, 3'd7,8'h00,2'd0,0,0));
        vecs.push_back(row(1,1,1,0,8'hEA,1,1,0, 3'd0,8'h00,2'd0,0,0));
        vecs.push_back(row(1,1,1,0,8'hEA,1,1,0, 3'd1,8'h00,2'd3,0,0));
        // New NMI edge in the same cycle as a consume keeps pending set.
        vecs.push_back(row(1,1,0,1,8'hA9,1,1,0, 3'd0,8'h00,2'd3,0,0));
        vecs.push_back(row(1,1,0,1,8'hA9,0,1,0, 3'd0,8'h00,2'd3,0,0));
        vecs.push_back(row(1,1,0,1,8'hA9,1,1,0, 3'd0,8'h00,2'd3,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,0,1,0, 3'd1,8'h00,2'd2,0,0));
        vecs.push_back(row(1,1,0,1,8'hA9,0,1,0, 3'd0,8'h00,2'd2,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,0,1,0, 3'd1,8'h00,2'd2,0,0));
        vecs.push_back(row(1,1,0,1,8'hA9,1,1,0, 3'd0,8'h00,2'd2,0,0));
        vecs.push_back(row(1,1,1,0,8'hA9,1,1,0, 3'd1,8'hA9,2'd0,0,0));

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // NMI edge arriving while RDY is low is remembered and serviced later.
        applyStimulus(row(1,0,1,0,8'hA9,0,1,0, 3'd1,8'hA9,2'd0,0,0), 100);
        applyStimulus(row(1,0,1,0,8'hA9,0,1,0, 3'd1,8'hA9,2'd0,0,0), 101);
        applyStimulus(row(1,1,0,1,8'hA9,0,1,0, 3'd0,8'hA9,2'd0,0,0), 102);
        applyStimulus(row(1,1,1,0,8'hA9,0,1,0, 3'd1,8'h00,2'd2,0,0), 103);

        // JAM opcode 02: halts and freezes the counter only when the feature is built.
        applyStimulus(row(1,1,0,1,8'h02,1,1,0, 3'd0,8'h00,2'd2,0,0), 200);
        applyStimulus(row(1,1,1,0,8'h02,1,1,0, 3'd1,8'h02,2'd0,0,JAM_EN), 201);
        applyStimulus(row(1,1,1,0,8'h02,1,1,0, JAM_EN ? 3'd1 : 3'd2,8'h02,2'd0,0,JAM_EN), 202);
        applyStimulus(row(1,1,1,0,8'h02,1,1,0, JAM_EN ? 3'd1 : 3'd3,8'h02,2'd0,0,JAM_EN), 203);
        applyStimulus(row(0,1,1,0,8'h02,1,1,0, 3'd7,8'h00,2'd0,0,0), 204);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
